// File: rtl/pwm_cfg_sequencer.sv
// PWM configuration sequencer: byte-write register port, enable commit, duty ramp.
// Optional macro PWM_CFG_SYNC_COMMIT_EN: shadow enables committed on period_start.
module pwm_cfg_sequencer #(
    parameter int unsigned RAMP_DIV = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       period_start,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       ramp_busy,
    output logic       addr_err
);

    typedef enum logic {
        S_IDLE,
        S_RAMP
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(RAMP_DIV - 1);

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            addr_err_q, addr_err_d;
    logic [7:0]      duty_q, duty_d;
    logic [7:0]      target_q, target_d;
    logic [7:0]      step_q, step_d;
    logic [15:0]     presc_q, presc_d;
    logic [3:0][7:0] act_q, act_d;

    logic            acc;
    logic            wr_duty;
    logic            wr_step;
    logic            wr_en;
    logic            tick;
    logic [7:0]      tgt_eff;
    logic [8:0]      up_sum;
    logic [8:0]      dn_diff;
    logic [7:0]      stepped;

`ifdef PWM_CFG_SYNC_COMMIT_EN
    logic [3:0][7:0] sh_q, sh_d;
`else
    logic            unused_period_start;
    assign unused_period_start = period_start;
`endif

    always_comb begin
        acc     = wr_valid && ready_q;
        wr_en   = acc && (wr_addr < 7'h04);
        wr_duty = acc && (wr_addr == 7'h04);
        wr_step = acc && (wr_addr == 7'h05);
        tick    = (state_q == S_RAMP) && (presc_q == PRESC_MAX);
        // A retarget coinciding with a tick steps toward the new target
        tgt_eff = wr_duty ? wr_data : target_q;
        up_sum  = {1'b0, duty_q} + {1'b0, step_q};
        dn_diff = {1'b0, duty_q} - {1'b0, step_q};
        stepped = duty_q;
        if (duty_q < tgt_eff) begin
            stepped = (up_sum >= {1'b0, tgt_eff}) ? tgt_eff : up_sum[7:0];
        end else if (duty_q > tgt_eff) begin
            stepped = (dn_diff[8] || (dn_diff[7:0] <= tgt_eff)) ?
                      tgt_eff : dn_diff[7:0];
        end
    end

    always_comb begin
        ready_d    = 1'b1;
        addr_err_d = acc && (wr_addr >= 7'h06);
        step_d     = wr_step ? wr_data : step_q;
        act_d      = act_q;
`ifdef PWM_CFG_SYNC_COMMIT_EN
        sh_d = sh_q;
        if (wr_en) begin
            sh_d[wr_addr[1:0]] = wr_data;
        end
        if (period_start) begin
            act_d = sh_d;
        end
`else
        if (wr_en) begin
            act_d[wr_addr[1:0]] = wr_data;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = wr_duty ? wr_data : target_q;
        presc_d  = presc_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_duty) begin
                    if (step_q == 8'h00) begin
                        duty_d = wr_data;
                    end else if (wr_data != duty_q) begin
                        state_d = S_RAMP;
                        presc_d = 16'h0000;
                    end
                end
            end
            S_RAMP: begin
                presc_d = tick ? 16'h0000 : presc_q + 16'h0001;
                if (wr_duty && (step_q == 8'h00)) begin
                    duty_d  = wr_data;
                    state_d = S_IDLE;
                end else begin
                    if (tick) begin
                        duty_d = stepped;
                    end
                    state_d = (duty_d == tgt_eff) ? S_IDLE : S_RAMP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
            duty_q     <= 8'h00;
            target_q   <= 8'h00;
            step_q     <= 8'h00;
            presc_q    <= 16'h0000;
            act_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
            duty_q     <= duty_d;
            target_q   <= target_d;
            step_q     <= step_d;
            presc_q    <= presc_d;
            act_q      <= act_d;
        end
    end

`ifdef PWM_CFG_SYNC_COMMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end
`endif

    assign wr_ready        = ready_q;
    assign addr_err        = addr_err_q;
    assign ramp_busy       = (state_q == S_RAMP);
    assign pwm_duty_cycle  = duty_q;
    assign en_reg_out_7_0  = act_q[0];
    assign en_reg_out_15_8 = act_q[1];
    assign en_reg_pwm_7_0  = act_q[2];
    assign en_reg_pwm_15_8 = act_q[3];

endmodule
